// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word per PC
// over a request/grant/response bus, and presents it (with fault flags) to decode.
//
// Handshake: ibus_req/ibus_addr are held stable from the first request cycle until
// the cycle ibus_gnt is seen with ibus_req high; the request is never withdrawn.
// A response (ibus_rvalid, with ibus_err qualifying it) is only accepted in WAIT,
// never in the grant cycle. inst/pc/flags are valid while inst_valid is high and are
// consumed by a one-cycle advance pulse, which also samples next_pc.
//
// Optional feature macro: IBUS_TIMEOUT_EN -- when defined, a fetch waiting longer
// than TIMEOUT_CYCLES for its response completes as an access fault.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        inst_access_fault,
    output logic        inst_misaligned,
    output logic        fetch_busy,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_MISAL = 2'd3
    } state_t;

    // Reject parameter values the hardware cannot honour.
    if (RESET_ADDR[1:0] != 2'b00) begin : g_bad_reset_addr
        $error("fetch_unit: RESET_ADDR must be word aligned");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t state_q;
    state_t state_d;
    logic   wait_done;   // response (or timeout) completes the fetch this cycle
    logic   wait_fault;  // completion is an access fault

`ifdef IBUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;

    // Count WAIT cycles without a response; cleared while requesting so it starts at 0 in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
        end else if (state_q == ST_REQ) begin
            tmo_cnt <= 8'd0;
        end else if (state_q == ST_WAIT && !ibus_rvalid) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and fetch-completion decode.
    always_comb begin
        state_d    = state_q;
        wait_done  = 1'b0;
        wait_fault = 1'b0;
        case (state_q)
            ST_REQ: begin
                // Responses are ignored here, which drops anything left over from before a reset.
                if (ibus_req && ibus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ibus_rvalid) begin
                    wait_done  = 1'b1;
                    wait_fault = ibus_err;
                end
`ifdef IBUS_TIMEOUT_EN
                else if (tmo_cnt == TIMEOUT_LAST) begin
                    wait_done  = 1'b1;
                    wait_fault = 1'b1;
                end
`endif
                if (wait_done) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (advance) begin
                    state_d = (next_pc[1:0] != 2'b00) ? ST_MISAL : ST_REQ;
                end
            end
            ST_MISAL: begin
                state_d = ST_VALID;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Registered datapath: PC, instruction word, flags and bus request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_ADDR;
            inst              <= NOP_INST;
            inst_valid        <= 1'b0;
            inst_access_fault <= 1'b0;
            inst_misaligned   <= 1'b0;
            fetch_busy        <= 1'b1;
            ibus_req          <= 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    // After reset the request rises one cycle late; it drops only on grant.
                    if (!ibus_req) begin
                        ibus_req <= 1'b1;
                    end else if (ibus_gnt) begin
                        ibus_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        inst              <= wait_fault ? NOP_INST : ibus_rdata;
                        inst_access_fault <= wait_fault;
                        inst_valid        <= 1'b1;
                        fetch_busy        <= 1'b0;
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        pc                <= next_pc;
                        inst_access_fault <= 1'b0;
                        inst_misaligned   <= 1'b0;
                        inst_valid        <= 1'b0;
                        fetch_busy        <= 1'b1;
                        // Aligned targets request immediately, so REQ starts with the bus driven.
                        ibus_req          <= (next_pc[1:0] == 2'b00);
                    end
                end
                ST_MISAL: begin
                    inst            <= NOP_INST;
                    inst_misaligned <= 1'b1;
                    inst_valid      <= 1'b1;
                    fetch_busy      <= 1'b0;
                end
                default: begin
                    ibus_req <= 1'b0;
                end
            endcase
        end
    end

    assign ibus_addr = pc;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bus responder driven from one initial block,
// with expected fetch results queued when a response is driven and checked when
// inst_valid appears.
module tb_fetch_unit;

    localparam logic [31:0] RST_ADDR = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          TMO      = 16;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_access_fault;
    logic        inst_misaligned;
    logic        fetch_busy;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        ibus_err;
    logic [1:0]  state_dbg;

    fetch_unit #(
        .RESET_ADDR    (RST_ADDR),
        .NOP_INST      (NOP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .next_pc          (next_pc),
        .advance          (advance),
        .pc               (pc),
        .inst             (inst),
        .inst_valid       (inst_valid),
        .inst_access_fault(inst_access_fault),
        .inst_misaligned  (inst_misaligned),
        .fetch_busy       (fetch_busy),
        .ibus_req         (ibus_req),
        .ibus_addr        (ibus_addr),
        .ibus_gnt         (ibus_gnt),
        .ibus_rvalid      (ibus_rvalid),
        .ibus_rdata       (ibus_rdata),
        .ibus_err         (ibus_err),
        .state_dbg        (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected fetch results: {pc, inst, access_fault, misaligned}.
    logic [65:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] epc, input logic [31:0] einst,
                            input logic eaf, input logic emis);
        exp_q.push_back({epc, einst, eaf, emis});
    endtask

    // Wait (bounded) for inst_valid, then compare against the oldest expected result.
    task automatic check_valid(input string tag, input int budget);
        int n = 0;
        logic [65:0] e;
        while (inst_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, inst_valid, 1);
        check({tag, "_busy"}, fetch_busy, 0);
        check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, pc, e[65:34]);
            check({tag, "_inst"}, inst, e[33:2]);
            check({tag, "_afault"}, inst_access_fault, e[1]);
            check({tag, "_misal"}, inst_misaligned, e[0]);
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (ibus_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, ibus_req, 1);
    endtask

    // Consume the current instruction and redirect to npc.
    task automatic do_advance(input string tag, input logic [31:0] npc);
        check({tag, "_pre_valid"}, inst_valid, 1);
        next_pc = npc;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        next_pc = $urandom;
        check({tag, "_pc_upd"}, pc, npc);
        check({tag, "_valid_clr"}, inst_valid, 0);
        check({tag, "_busy_set"}, fetch_busy, 1);
        check({tag, "_af_clr"}, inst_access_fault, 0);
    endtask

    // Serve one aligned fetch with the given grant and response delays.
    task automatic bus_fetch(input string tag, input logic [31:0] addr, input int gnt_dly,
                             input int rv_dly, input logic [31:0] data, input logic err);
        wait_req(tag, 8);
        check({tag, "_addr"}, ibus_addr, addr);
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check({tag, "_req_hold"}, ibus_req, 1);
            check({tag, "_addr_hold"}, ibus_addr, addr);
        end
        ibus_gnt = 1'b1;
        @(negedge clk);
        ibus_gnt = 1'b0;
        check({tag, "_req_drop"}, ibus_req, 0);
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk);
            check({tag, "_wait_busy"}, inst_valid, 0);
        end
        ibus_rvalid = 1'b1;
        ibus_rdata  = data;
        ibus_err    = err;
        push_exp(addr, err ? NOP : data, err, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        ibus_err    = 1'b0;
        ibus_rdata  = $urandom;
        check_valid(tag, 2);
    endtask

    initial begin
        logic [31:0] a;
        rst         = 1'b1;
        next_pc     = 32'h0;
        advance     = 1'b0;
        ibus_gnt    = 1'b0;
        ibus_rvalid = 1'b0;
        ibus_rdata  = 32'h0;
        ibus_err    = 1'b0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, RST_ADDR);
        check("rst_inst", inst, NOP);
        check("rst_valid", inst_valid, 0);
        check("rst_af", inst_access_fault, 0);
        check("rst_mis", inst_misaligned, 0);
        check("rst_req", ibus_req, 0);
        check("rst_busy", fetch_busy, 1);
        check("rst_state", state_dbg, 2'd0);

        // First fetch after reset: request in cycle 1, valid on cycle 3.
        rst = 1'b0;
        @(negedge clk);
        check("boot_req", ibus_req, 1);
        check("boot_addr", ibus_addr, RST_ADDR);
        ibus_gnt = 1'b1;
        @(negedge clk);
        ibus_gnt = 1'b0;
        check("boot_c2_valid", inst_valid, 0);
        ibus_rvalid = 1'b1;
        ibus_rdata  = 32'h0010_0093;
        push_exp(RST_ADDR, 32'h0010_0093, 1'b0, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        check_valid("boot", 0);

        // Delayed grant: request and address stable; advance outside VALID ignored.
        do_advance("adv104", 32'h0000_0104);
        check("d_req", ibus_req, 1);
        check("d_addr", ibus_addr, 32'h0000_0104);
        next_pc = 32'hDEAD_0000;
        advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d_req_hold", ibus_req, 1);
            check("d_addr_hold", ibus_addr, 32'h0000_0104);
            check("d_pc_hold", pc, 32'h0000_0104);
        end
        advance = 1'b0;
        ibus_gnt = 1'b1;
        @(negedge clk);
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1;
        ibus_rdata  = 32'h00A0_0513;
        push_exp(32'h0000_0104, 32'h00A0_0513, 1'b0, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        check_valid("delayed", 0);

        // Bus error response, then the flag clears on advance.
        do_advance("adv108", 32'h0000_0108);
        bus_fetch("err", 32'h0000_0108, 0, 1, 32'hFFFF_FFFF, 1'b1);
        do_advance("adv_after_err", 32'h0000_0200);
        bus_fetch("post_err", 32'h0000_0200, 1, 0, 32'h1234_5678, 1'b0);

        // Misaligned target: no bus request, valid two cycles after advance.
        do_advance("adv106", 32'h0000_0106);
        push_exp(32'h0000_0106, NOP, 1'b0, 1'b1);
        check("mis_c1_req", ibus_req, 0);
        @(negedge clk);
        check("mis_c2_req", ibus_req, 0);
        check_valid("misal", 0);
        do_advance("adv_after_mis", 32'h0000_0300);
        check("mis_clr", inst_misaligned, 0);
        bus_fetch("post_mis", 32'h0000_0300, 0, 0, 32'h0000_0297, 1'b0);

        // Randomised aligned fetches.
        for (int i = 0; i < 6; i++) begin
            a = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
            do_advance("rnd_adv", a);
            bus_fetch("rnd", a, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, ($urandom_range(0, 3) == 0));
        end

        // Reset in WAIT; a stale response during the following REQ is dropped.
        do_advance("adv400", 32'h0000_0400);
        wait_req("rw", 4);
        ibus_gnt = 1'b1;
        @(negedge clk);
        ibus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("rw_pc", pc, RST_ADDR);
        check("rw_req", ibus_req, 0);
        check("rw_busy", fetch_busy, 1);
        check("rw_state", state_dbg, 2'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ibus_rvalid = 1'b1;
        ibus_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        ibus_rvalid = 1'b0;
        check("rw_stale_valid", inst_valid, 0);
        check("rw_stale_req", ibus_req, 1);
        bus_fetch("rw_fresh", RST_ADDR, 0, 0, 32'h0040_0113, 1'b0);

        // Response timeout (or indefinite wait when the feature is off).
        do_advance("adv500", 32'h0000_0500);
        wait_req("tmo", 4);
        ibus_gnt = 1'b1;
        @(negedge clk);
        ibus_gnt = 1'b0;
`ifdef IBUS_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            check("tmo_waiting", inst_valid, 0);
        end
        push_exp(32'h0000_0500, NOP, 1'b1, 1'b0);
        @(negedge clk);
        check_valid("tmo", 0);
        ibus_rvalid = 1'b1;
        ibus_rdata  = 32'h0BAD_0BAD;
        @(negedge clk);
        ibus_rvalid = 1'b0;
        check("tmo_late_inst", inst, NOP);
        check("tmo_late_af", inst_access_fault, 1);
        check("tmo_late_req", ibus_req, 0);
`else
        for (int i = 0; i < 3 * TMO; i++) begin
            @(negedge clk);
        end
        check("hold_waiting", inst_valid, 0);
        check("hold_req", ibus_req, 0);
        ibus_rvalid = 1'b1;
        ibus_rdata  = 32'h0000_0513;
        push_exp(32'h0000_0500, 32'h0000_0513, 1'b0, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        check_valid("hold", 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
